dct_stage2_transpose_buf: RTL and testbench

- Parametrised successor to the stage-2 register column: an N x N ping-pong transpose buffer between DCT stage 1 (row pass) and stage 2 (column pass).
- Accepts one N-element row per beat and emits one N-element column per beat.
- Two banks let block k+1 fill while block k drains.
- Valid/ready handshakes on both sides replace the bare write enable.

---
 rtl/dct_stage2_transpose_buf.sv | 152 +++++++++++++++
 tb/tb_dct_stage2_transpose_buf.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dct_stage2_transpose_buf.sv
// N x N ping-pong transpose buffer: rows in, columns out, valid/ready on both sides.
// Optional synchronous flush port enabled by defining DCT_TBUF_FLUSH_EN.
module dct_stage2_transpose_buf #(
  parameter int SIZE = 12,
  parameter int N    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
`ifdef DCT_TBUF_FLUSH_EN
  input  logic                       flush,
`endif
  input  logic                       wr_en,
  output logic                       in_ready,
  input  logic signed [SIZE-1:0]     data_in  [N],
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [SIZE-1:0]     data_out [N],
  output logic [$clog2(N)-1:0]       out_col,
  output logic                       out_last
);

  localparam int             CW   = $clog2(N);
  localparam logic [CW-1:0]  LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_e;

  bank_state_e              state_q [2];
  bank_state_e              state_d [2];
  logic                     wr_bank_q, wr_bank_d;
  logic                     rd_bank_q, rd_bank_d;
  logic [CW-1:0]            wr_row_q, wr_row_d;
  logic [CW-1:0]            rd_col_q, rd_col_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [SIZE-1:0]   mem_q [2][N][N];

  logic flush_w;
  logic accept;
  logic transfer;

`ifdef DCT_TBUF_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  assign in_ready = (state_q[wr_bank_q] == EMPTY) || (state_q[wr_bank_q] == FILLING);
  assign accept   = wr_en && in_ready && !flush_w;
  assign transfer = out_valid_q && out_ready && !flush_w;

  assign out_valid = out_valid_q;
  assign out_col   = rd_col_q;
  assign out_last  = out_valid_q && (rd_col_q == LAST);

  always_comb begin
    for (int r = 0; r < N; r++) begin
      data_out[r] = mem_q[rd_bank_q][r][rd_col_q];
    end
  end

  // Write effects are applied first so a bank completing this cycle can launch
  // its first column on the same edge, giving one-cycle latency and no gaps.
  always_comb begin
    state_d     = state_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wr_row_d    = wr_row_q;
    rd_col_d    = rd_col_q;
    out_valid_d = out_valid_q;

    if (accept) begin
      if (state_d[wr_bank_q] == EMPTY) begin
        state_d[wr_bank_q] = FILLING;
      end
      if (wr_row_q == LAST) begin
        state_d[wr_bank_q] = FULL;
        wr_row_d           = '0;
        wr_bank_d          = ~wr_bank_q;
      end else begin
        wr_row_d = wr_row_q + 1'b1;
      end
    end

    if (transfer) begin
      if (rd_col_q == LAST) begin
        state_d[rd_bank_q] = EMPTY;
        rd_col_d           = '0;
        rd_bank_d          = ~rd_bank_q;
        out_valid_d        = 1'b0;
      end else begin
        rd_col_d = rd_col_q + 1'b1;
      end
    end

    if (!out_valid_d && (state_d[rd_bank_d] == FULL)) begin
      state_d[rd_bank_d] = DRAINING;
      out_valid_d        = 1'b1;
    end

    if (flush_w) begin
      state_d[0]  = EMPTY;
      state_d[1]  = EMPTY;
      wr_bank_d   = 1'b0;
      rd_bank_d   = 1'b0;
      wr_row_d    = '0;
      rd_col_d    = '0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q[0]  <= EMPTY;
      state_q[1]  <= EMPTY;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_row_q    <= '0;
      rd_col_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q[0]  <= state_d[0];
      state_q[1]  <= state_d[1];
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_row_q    <= wr_row_d;
      rd_col_q    <= rd_col_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Storage survives a flush; only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < N; r++) begin
          for (int c = 0; c < N; c++) begin
            mem_q[b][r][c] <= '0;
          end
        end
      end
    end else if (accept) begin
      for (int c = 0; c < N; c++) begin
        mem_q[wr_bank_q][wr_row_q][c] <= data_in[c];
      end
    end
  end

endmodule

// File: tb/tb_dct_stage2_transpose_buf.sv
// Scoreboard bench for dct_stage2_transpose_buf (N=8, SIZE=12) using a block-level
// reference model: accepted rows form blocks, and each finished block queues its columns.
module tb_dct_stage2_transpose_buf;

   localparam int N    = 8;
   localparam int SIZE = 12;

   logic                    clk;
   logic                    rst;
   logic                    wrEn;
   logic                    inReady;
   logic signed [SIZE-1:0]  dIn  [N];
   logic                    outValid;
   logic                    outReady;
   logic signed [SIZE-1:0]  dOut [N];
   logic [2:0]              outCol;
   logic                    outLast;

   typedef struct {
      logic [N*SIZE-1:0] d;
      int                col;
   } colT;

   colT                     expQ[$];
   logic signed [SIZE-1:0]  blk [N][N];
   int                      rowsIn;
   int                      written;
   int                      drained;
   int                      colsOut;
   int                      nChecks;
   int                      nErrors;
   bit                      wDone;

   dct_stage2_transpose_buf #(.SIZE(SIZE), .N(N)) dut (
      .clk       (clk),
      .rst       (rst),
`ifdef DCT_TBUF_FLUSH_EN
      .flush     (1'b0),
`endif
      .wr_en     (wrEn),
      .in_ready  (inReady),
      .data_in   (dIn),
      .out_valid (outValid),
      .out_ready (outReady),
      .data_out  (dOut),
      .out_col   (outCol),
      .out_last  (outLast)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErrors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Offer one row and hold it until the buffer takes it.
   task automatic applyStimulus(input logic [N*SIZE-1:0] row);
      bit acc;
      int tries;
      acc   = 1'b0;
      tries = 0;
      wrEn  = 1'b1;
      for (int c = 0; c < N; c++) dIn[c] = row[c*SIZE +: SIZE];
      while (!acc && tries < 300) begin
         @(negedge clk);
         acc = inReady;
         @(posedge clk);
         #1;
         tries++;
      end
      if (!acc) checkOutput("row_accept_timeout", 0, 1);
      wrEn = 1'b0;
   endtask

   function automatic logic [N*SIZE-1:0] patRow(input int base, input int r, input int step);
      logic [N*SIZE-1:0] v;
      for (int c = 0; c < N; c++) v[c*SIZE +: SIZE] = SIZE'(base + r*step + c);
      return v;
   endfunction

   task automatic waitDrain();
      int cyc;
      cyc = 0;
      while ((expQ.size() != 0 || written != drained || rowsIn != 0) && cyc < 500) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      if (cyc >= 500) checkOutput("drain_timeout", 0, 1);
   endtask

   // Monitor and reference model: bank occupancy is simply completed blocks minus drained blocks.
   always @(negedge clk) begin
      if (!rst) begin
         rowsIn  = 0;
         written = 0;
         drained = 0;
         colsOut = 0;
         expQ.delete();
      end else begin
         int held;
         held = written - drained;
         checkOutput("in_ready", inReady, (held < 2));
         checkOutput("out_valid", outValid, (held > 0));
         if (!outValid) checkOutput("out_last_idle", outLast, 0);
         if (wrEn && inReady) begin
            for (int c = 0; c < N; c++) blk[rowsIn][c] = dIn[c];
            rowsIn++;
            if (rowsIn == N) begin
               for (int c = 0; c < N; c++) begin
                  colT e;
                  for (int r = 0; r < N; r++) e.d[r*SIZE +: SIZE] = blk[r][c];
                  e.col = c;
                  expQ.push_back(e);
               end
               written++;
               rowsIn = 0;
            end
         end
         if (outValid && outReady) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_column", 1, 0);
            end else begin
               colT e;
               logic [N*SIZE-1:0] act;
               e = expQ.pop_front();
               for (int r = 0; r < N; r++) act[r*SIZE +: SIZE] = dOut[r];
               checkOutput("column_data", act, e.d);
               checkOutput("out_col", outCol, e.col);
               checkOutput("out_last", outLast, (e.col == N-1));
            end
            colsOut++;
            if (colsOut == N) begin
               drained++;
               colsOut = 0;
            end
         end
      end
   end

   initial begin
      rst      = 1'b0;
      wrEn     = 1'b0;
      outReady = 1'b0;
      wDone    = 1'b0;
      nChecks  = 0;
      nErrors  = 0;
      for (int c = 0; c < N; c++) dIn[c] = '0;

      @(negedge clk);
      checkOutput("reset_out_valid", outValid, 0);
      checkOutput("reset_in_ready", inReady, 1);
      checkOutput("reset_out_col", outCol, 0);
      checkOutput("reset_out_last", outLast, 0);
      checkOutput("reset_data_out0", dOut[0], 0);
      checkOutput("reset_data_out7", dOut[7], 0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Single block, column 0 visible the cycle after the last row.
      outReady = 1'b1;
      for (int r = 0; r < N; r++) applyStimulus(patRow(0, r, 16));
      @(negedge clk);
      checkOutput("t1_valid_latency", outValid, 1);
      checkOutput("t1_col0_r1", dOut[1], 16);
      checkOutput("t1_col0_r7", dOut[7], 112);
      @(posedge clk);
      #1;
      waitDrain();

      // Four blocks streamed back to back.
      for (int k = 0; k < 4; k++)
         for (int r = 0; r < N; r++) applyStimulus(patRow(k*256, r, 16));
      waitDrain();

      // Backpressure: two blocks fill both banks, the 17th row stalls.
      outReady = 1'b0;
      for (int k = 0; k < 2; k++)
         for (int r = 0; r < N; r++) applyStimulus(patRow(k*256, r, 16));
      wrEn = 1'b1;
      for (int c = 0; c < N; c++) dIn[c] = SIZE'(1000 + c);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("bp_in_ready_low", inReady, 0);
         checkOutput("bp_hold_col", outCol, 0);
         checkOutput("bp_hold_r3", dOut[3], 48);
         @(posedge clk);
         #1;
      end
      wrEn     = 1'b0;
      outReady = 1'b1;
      waitDrain();

      // Negative values and both extremes.
      for (int r = 0; r < N; r++) applyStimulus(patRow(-2048, r, N));
      for (int r = 0; r < N; r++) begin
         logic [N*SIZE-1:0] v;
         for (int c = 0; c < N; c++) v[c*SIZE +: SIZE] = SIZE'(2047 - r*N - c);
         applyStimulus(v);
      end
      waitDrain();

      // Reset after five rows discards the partial block.
      for (int r = 0; r < 5; r++) applyStimulus(patRow(500, r, 16));
      rst = 1'b0;
      @(negedge clk);
      checkOutput("midrst_out_valid", outValid, 0);
      checkOutput("midrst_in_ready", inReady, 1);
      checkOutput("midrst_data_out0", dOut[0], 0);
      checkOutput("midrst_data_out4", dOut[4], 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      for (int r = 0; r < N; r++) applyStimulus(patRow(5, r, 16));
      waitDrain();

      // Random data, random write gaps, random downstream readiness.
      fork
         begin
            for (int k = 0; k < 6; k++) begin
               for (int r = 0; r < N; r++) begin
                  logic [N*SIZE-1:0] v;
                  int gap;
                  gap = $urandom_range(0, 2);
                  for (int g = 0; g < gap; g++) begin
                     @(posedge clk);
                     #1;
                  end
                  for (int c = 0; c < N; c++) v[c*SIZE +: SIZE] = SIZE'($urandom);
                  applyStimulus(v);
               end
            end
            wDone = 1'b1;
         end
         begin
            while (!wDone) begin
               outReady = 1'($urandom_range(0, 1));
               @(posedge clk);
               #1;
            end
         end
      join
      outReady = 1'b1;
      waitDrain();

      $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
      $finish;
   end

endmodule
